deserializer_generic: RTL



---
 rtl/deser_pkg.sv | 14 +
 rtl/deserializer_generic.sv | 117 +++++++++++
 2 files changed

// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and sizing helpers for deserializer_generic
package deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } deser_state_e;

  // Counter width for a WIDTH-bit word; WIDTH is at least 2 so this is never 0.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/deserializer_generic.sv
// rtl/deserializer_generic.sv - LSB-first serial-to-parallel receiver with realign
// Optional even-parity bit and parity_err output when DESER_PARITY_EN is defined.
module deserializer_generic
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_in,
  input  logic             w_valid,
  input  logic             sync_in,
  output logic [WIDTH-1:0] f_out,
  output logic             f_valid,
  output logic             busy
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] f_out_q;
  logic             f_valid_q;
  logic             busy_q;
`ifdef DESER_PARITY_EN
  deser_state_e     state_q;
  logic             par_q;
  logic             parity_err_q;
`endif

  // Collect register with the incoming bit merged at the current position.
  always_comb begin
    word_d         = sh_q;
    word_d[cnt_q]  = w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sh_q         <= '0;
      f_out_q      <= '0;
      f_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DESER_PARITY_EN
      state_q      <= COLLECT;
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      f_valid_q    <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (sync_in) begin
        // Realign: a coincident valid bit becomes bit 0 of the new word.
`ifdef DESER_PARITY_EN
        state_q <= COLLECT;
        par_q   <= w_valid & w_in;
`endif
        if (w_valid) begin
          sh_q[0] <= w_in;
          cnt_q   <= CW'(1);
          busy_q  <= 1'b1;
        end else begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      end else if (w_valid) begin
`ifdef DESER_PARITY_EN
        if (state_q == PARITY) begin
          f_out_q      <= sh_q;
          f_valid_q    <= 1'b1;
          parity_err_q <= par_q ^ w_in;
          par_q        <= 1'b0;
          state_q      <= COLLECT;
          busy_q       <= 1'b0;
        end else begin
          sh_q  <= word_d;
          par_q <= par_q ^ w_in;
          busy_q <= 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= PARITY;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`else
        sh_q <= word_d;
        if (cnt_q == LAST) begin
          cnt_q     <= '0;
          f_out_q   <= word_d;
          f_valid_q <= 1'b1;
          busy_q    <= 1'b0;
        end else begin
          cnt_q  <= cnt_q + CW'(1);
          busy_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign f_out   = f_out_q;
  assign f_valid = f_valid_q;
  assign busy    = busy_q;
`ifdef DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
